// File: rtl/pulse_controller.sv
// Sequencing for one APU pulse channel: register decode, period timer,
// length counter and envelope generator feeding the waveform generator and mixer.
module pulse_controller #(
    parameter int unsigned TIMER_WIDTH    = 11,
    parameter int unsigned MUTE_THRESHOLD = 8
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iTick,
    input  logic       iQuarterFrame,
    input  logic       iHalfFrame,
    input  logic       iChannelEnable,
    input  logic       iWrite,
    input  logic [1:0] iAddr,
    input  logic [7:0] iData,
    output logic [1:0] oDuty,
    output logic       oStep,
    output logic       oPhaseReset,
    output logic       oEnable,
    output logic [3:0] oVolume,
    output logic       oActive
);

    localparam int unsigned LEN_W = 8;
    localparam int unsigned ENV_W = 4;

    // Length counter load values indexed by iData[7:3] of a reg-3 write.
    function automatic logic [LEN_W-1:0] lenLookup(input logic [4:0] idx);
        case (idx)
            5'd0:  lenLookup = 8'd10;   5'd1:  lenLookup = 8'd254;
            5'd2:  lenLookup = 8'd20;   5'd3:  lenLookup = 8'd2;
            5'd4:  lenLookup = 8'd40;   5'd5:  lenLookup = 8'd4;
            5'd6:  lenLookup = 8'd80;   5'd7:  lenLookup = 8'd6;
            5'd8:  lenLookup = 8'd160;  5'd9:  lenLookup = 8'd8;
            5'd10: lenLookup = 8'd60;   5'd11: lenLookup = 8'd10;
            5'd12: lenLookup = 8'd14;   5'd13: lenLookup = 8'd12;
            5'd14: lenLookup = 8'd26;   5'd15: lenLookup = 8'd14;
            5'd16: lenLookup = 8'd12;   5'd17: lenLookup = 8'd16;
            5'd18: lenLookup = 8'd24;   5'd19: lenLookup = 8'd18;
            5'd20: lenLookup = 8'd48;   5'd21: lenLookup = 8'd20;
            5'd22: lenLookup = 8'd96;   5'd23: lenLookup = 8'd22;
            5'd24: lenLookup = 8'd192;  5'd25: lenLookup = 8'd24;
            5'd26: lenLookup = 8'd72;   5'd27: lenLookup = 8'd26;
            5'd28: lenLookup = 8'd16;   5'd29: lenLookup = 8'd28;
            5'd30: lenLookup = 8'd32;   default: lenLookup = 8'd30;
        endcase
    endfunction

    logic [1:0]             dutyReg, dutyNext;
    logic                   haltLoop, haltLoopNext;
    logic                   constVol, constVolNext;
    logic [ENV_W-1:0]       volParam, volParamNext;
    logic [TIMER_WIDTH-1:0] period, periodNext;
    logic [TIMER_WIDTH-1:0] timerCount, timerCountNext;
    logic [LEN_W-1:0]       lengthCount, lengthCountNext;
    logic [ENV_W-1:0]       envDivider, envDividerNext;
    logic [ENV_W-1:0]       decay, decayNext;
    logic                   startFlag, startFlagNext;
    logic                   stepNext;
    logic                   phaseResetNext;
    logic                   muteNext;
    logic                   writeReg3;

    assign writeReg3 = iWrite && (iAddr == 2'd3);

    // Next-state logic for registers, timer, length counter and envelope.
    always_comb begin
        dutyNext        = dutyReg;
        haltLoopNext    = haltLoop;
        constVolNext    = constVol;
        volParamNext    = volParam;
        periodNext      = period;
        timerCountNext  = timerCount;
        lengthCountNext = lengthCount;
        envDividerNext  = envDivider;
        decayNext       = decay;
        startFlagNext   = startFlag;
        stepNext        = 1'b0;
        phaseResetNext  = 1'b0;

        if (iWrite) begin
            case (iAddr)
                2'd0: begin
                    dutyNext     = iData[7:6];
                    haltLoopNext = iData[5];
                    constVolNext = iData[4];
                    volParamNext = iData[3:0];
                end
                2'd2: periodNext[7:0] = iData;
                2'd3: begin
                    periodNext[TIMER_WIDTH-1:8] = iData[TIMER_WIDTH-9:0];
                    phaseResetNext              = 1'b1;
                end
                default: ;
            endcase
        end

        // Reload uses the period currently held, so writes land at the next reload.
        if (iTick) begin
            if (timerCount == '0) begin
                timerCountNext = period;
                stepNext       = 1'b1;
            end else begin
                timerCountNext = timerCount - TIMER_WIDTH'(1);
            end
        end

        if (!iChannelEnable) begin
            lengthCountNext = '0;
        end else if (writeReg3) begin
            lengthCountNext = lenLookup(iData[7:3]);
        end else if (iHalfFrame && !haltLoop && (lengthCount != '0)) begin
            lengthCountNext = lengthCount - LEN_W'(1);
        end

        if (iQuarterFrame) begin
            if (startFlag) begin
                startFlagNext  = 1'b0;
                decayNext      = 4'hF;
                envDividerNext = volParam;
            end else if (envDivider == '0) begin
                envDividerNext = volParam;
                if (decay != '0) begin
                    decayNext = decay - ENV_W'(1);
                end else if (haltLoop) begin
                    decayNext = 4'hF;
                end
            end else begin
                envDividerNext = envDivider - ENV_W'(1);
            end
        end

        // A write coinciding with a quarter frame leaves the flag for the next one.
        if (writeReg3) begin
            startFlagNext = 1'b1;
        end

        muteNext = (periodNext < TIMER_WIDTH'(MUTE_THRESHOLD));
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            dutyReg     <= '0;
            haltLoop    <= 1'b0;
            constVol    <= 1'b0;
            volParam    <= '0;
            period      <= '0;
            timerCount  <= '0;
            lengthCount <= '0;
            envDivider  <= '0;
            decay       <= '0;
            startFlag   <= 1'b0;
            oDuty       <= '0;
            oStep       <= 1'b0;
            oPhaseReset <= 1'b0;
            oEnable     <= 1'b0;
            oVolume     <= '0;
            oActive     <= 1'b0;
        end else begin
            dutyReg     <= dutyNext;
            haltLoop    <= haltLoopNext;
            constVol    <= constVolNext;
            volParam    <= volParamNext;
            period      <= periodNext;
            timerCount  <= timerCountNext;
            lengthCount <= lengthCountNext;
            envDivider  <= envDividerNext;
            decay       <= decayNext;
            startFlag   <= startFlagNext;
            // Outputs track the state being loaded on this same edge.
            oDuty       <= dutyNext;
            oStep       <= stepNext;
            oPhaseReset <= phaseResetNext;
            oEnable     <= (lengthCountNext != '0) && !muteNext;
            oActive     <= (lengthCountNext != '0);
            if ((lengthCountNext == '0) || muteNext) begin
                oVolume <= '0;
            end else if (constVolNext) begin
                oVolume <= volParamNext;
            end else begin
                oVolume <= decayNext;
            end
        end
    end

endmodule

// File: tb/tb_pulse_controller.sv
// Directed bench for pulse_controller: a vector table for register/length/mute
// behaviour plus hand-written timer, length and envelope sequences.
module tb_pulse_controller;

    logic       clk = 1'b0;
    logic       iReset, iTick, iQuarterFrame, iHalfFrame, iChannelEnable, iWrite;
    logic [1:0] iAddr;
    logic [7:0] iData;
    logic [1:0] oDuty;
    logic       oStep, oPhaseReset, oEnable, oActive;
    logic [3:0] oVolume;

    int checks   = 0;
    int failures = 0;

    pulse_controller dut (
        .clk(clk), .iReset(iReset), .iTick(iTick), .iQuarterFrame(iQuarterFrame),
        .iHalfFrame(iHalfFrame), .iChannelEnable(iChannelEnable), .iWrite(iWrite),
        .iAddr(iAddr), .iData(iData), .oDuty(oDuty), .oStep(oStep),
        .oPhaseReset(oPhaseReset), .oEnable(oEnable), .oVolume(oVolume), .oActive(oActive)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, we, en, tk, hf;
        logic [1:0] addr;
        logic [7:0] data;
        logic [1:0] eDuty;
        logic       ePhase, eEnable, eActive, eStep;
        logic [3:0] eVol;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic we, input logic [1:0] a, input logic [7:0] d,
                       input logic en, input logic tk, input logic qf, input logic hf);
        iReset = rst; iWrite = we; iAddr = a; iData = d;
        iChannelEnable = en; iTick = tk; iQuarterFrame = qf; iHalfFrame = hf;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic tk, input logic qf, input logic hf);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, tk, qf, hf);
    endtask

    task automatic doReset();
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //            rst we  en  tk  hf  addr   data   duty ph  ena act stp vol
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,2'd3,8'hFF,2'd0,1'b0,1'b0,1'b0,1'b0,4'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,8'hBF,2'd2,1'b0,1'b0,1'b0,1'b0,4'd0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd2,8'h10,2'd2,1'b0,1'b0,1'b0,1'b0,4'd0};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd3,8'h00,2'd2,1'b1,1'b1,1'b1,1'b0,4'd15};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,8'h00,2'd2,1'b0,1'b1,1'b1,1'b0,4'd15};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd1,8'hFF,2'd2,1'b0,1'b1,1'b1,1'b0,4'd15};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd2,8'h05,2'd2,1'b0,1'b0,1'b1,1'b0,4'd0};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd2,8'h07,2'd2,1'b0,1'b0,1'b1,1'b0,4'd0};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd2,8'h08,2'd2,1'b0,1'b1,1'b1,1'b0,4'd15};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00,2'd2,1'b0,1'b0,1'b0,1'b0,4'd0};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'd3,8'h08,2'd2,1'b1,1'b0,1'b0,1'b0,4'd0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,8'h9F,2'd2,1'b0,1'b0,1'b0,1'b0,4'd0};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd3,8'h08,2'd2,1'b1,1'b1,1'b1,1'b0,4'd15};

        iReset = 1'b1; iTick = 1'b0; iQuarterFrame = 1'b0; iHalfFrame = 1'b0;
        iChannelEnable = 1'b0; iWrite = 1'b0; iAddr = '0; iData = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].data,
                vecs[i].en, vecs[i].tk, 1'b0, vecs[i].hf);
            chk($sformatf("vec%0d duty", i), oDuty, vecs[i].eDuty);
            chk($sformatf("vec%0d phase", i), oPhaseReset, vecs[i].ePhase);
            chk($sformatf("vec%0d enable", i), oEnable, vecs[i].eEnable);
            chk($sformatf("vec%0d active", i), oActive, vecs[i].eActive);
            chk($sformatf("vec%0d step", i), oStep, vecs[i].eStep);
            chk($sformatf("vec%0d volume", i), oVolume, vecs[i].eVol);
        end

        // Length 254 loaded alongside a half frame must not have been decremented.
        for (int i = 0; i < 253; i++) idle(1'b0, 1'b0, 1'b1);
        chk("len254 after 253 hf", oActive, 1);
        idle(1'b0, 1'b0, 1'b1);
        chk("len254 after 254 hf", oActive, 0);

        // Reset held with ticks and writes: everything stays at zero.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 2'($urandom_range(3)), 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
            chk("reset outputs", {oDuty, oStep, oPhaseReset, oEnable, oVolume, oActive}, 0);
        end

        // Period 16: step every 17 ticks, first on the first tick.
        doReset();
        wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h00);
        chk("p16 phase pulse", oPhaseReset, 1);
        for (int c = 1; c <= 60; c++) begin
            idle(1'b1, 1'b0, 1'b0);
            chk($sformatf("p16 step c%0d", c), oStep, ((c - 1) % 17 == 0) ? 1 : 0);
            if (c == 1) chk("p16 phase cleared", oPhaseReset, 0);
        end
        chk("p16 duty", oDuty, 2);
        chk("p16 volume", oVolume, 15);
        chk("p16 active", oActive, 1);

        // Period 5: muted, still stepping every 6 ticks.
        doReset();
        wr(2'd0, 8'hBF); wr(2'd2, 8'h05); wr(2'd3, 8'h00);
        for (int c = 1; c <= 30; c++) begin
            idle(1'b1, 1'b0, 1'b0);
            chk($sformatf("p5 step c%0d", c), oStep, ((c - 1) % 6 == 0) ? 1 : 0);
        end
        chk("p5 volume", oVolume, 0);
        chk("p5 enable", oEnable, 0);
        chk("p5 active", oActive, 1);

        // Length 2 counts down, halted length holds, enable drop clears.
        doReset();
        wr(2'd0, 8'h1F); wr(2'd2, 8'h10); wr(2'd3, 8'h18);
        idle(1'b0, 1'b0, 1'b1);
        chk("len2 after 1 hf", oActive, 1);
        idle(1'b0, 1'b0, 1'b1);
        chk("len2 after 2 hf", oActive, 0);
        wr(2'd0, 8'h3F); wr(2'd3, 8'h18);
        for (int i = 0; i < 10; i++) idle(1'b0, 1'b0, 1'b1);
        chk("halted len active", oActive, 1);
        chk("halted len volume", oVolume, 15);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("enable drop clears", oActive, 0);

        // Envelope with V=2: 15 on first quarter frame, then down every 3rd.
        doReset();
        wr(2'd0, 8'h02); wr(2'd2, 8'h10); wr(2'd3, 8'h00);
        chk("env before qf", oVolume, 0);
        for (int q = 1; q <= 49; q++) begin
            int expVol;
            idle(1'b0, 1'b1, 1'b0);
            expVol = (q == 1) ? 15 : ((q >= 46) ? 0 : 15 - (q - 1) / 3);
            chk($sformatf("env qf%0d", q), oVolume, expVol);
        end
        wr(2'd0, 8'h22);
        idle(1'b0, 1'b1, 1'b0);
        chk("env loop qf50", oVolume, 0);
        idle(1'b0, 1'b1, 1'b0);
        chk("env loop qf51", oVolume, 0);
        idle(1'b0, 1'b1, 1'b0);
        chk("env loop wrap", oVolume, 15);

        // Reset mid-operation drops pending strobes immediately.
        wr(2'd2, 8'h00);
        cyc(1'b1, 1'b1, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset drops strobes", {oStep, oPhaseReset, oActive}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
